keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl_pkg.sv | 41 ++++
 rtl/btn_sync_edge.sv | 32 +++
 rtl/keypad_entry_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// rtl/keypad_entry_ctrl_pkg.sv - shared state encoding, key codes and display glyphs
package keypad_entry_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENTRY  = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_OPEN   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;
    localparam logic [2:0] ST_LOCKED = 3'd5;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'h09;
    localparam logic [4:0] KEY_CLEAR     = 5'h0A;
    localparam logic [4:0] KEY_ENTER     = 5'h0F;

    localparam logic [4:0] GLYPH_BLANK = 5'h1F;
    localparam logic [4:0] GLYPH_LOCK  = 5'h0E;

    typedef enum logic [1:0] {
        KEV_NONE,
        KEV_DIGIT,
        KEV_CLEAR,
        KEV_ENTER
    } key_event_e;

    // A keypad strobe always wins over a same-cycle push-button edge.
    function automatic key_event_e decode_key(input logic       valid,
                                              input logic [4:0] code,
                                              input logic       enter_edge);
        key_event_e ev;
        ev = KEV_NONE;
        if (valid) begin
            if (code <= KEY_DIGIT_MAX)   ev = KEV_DIGIT;
            else if (code == KEY_CLEAR)  ev = KEV_CLEAR;
            else if (code == KEY_ENTER)  ev = KEV_ENTER;
        end else if (enter_edge) begin
            ev = KEV_ENTER;
        end
        return ev;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer and rising-edge detector for a raw button
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [2:0] r_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_arm  <= 3'b000;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_arm  <= {r_arm[1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chain holds real samples, so a button
    // already held across reset release does not count as a press.
    assign o_rise = r_arm[2] & r_sync & ~r_prev;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - 3-digit keypad access controller with fail lockout
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter logic [11:0] CODE        = 12'h147,
    parameter int          SHOW_CYCLES = 50_000_000,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCK_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    input  logic       enter,
    output logic [4:0] c,
    output logic [4:0] d,
    output logic [4:0] u,
    output logic       open,
    output logic       error,
    output logic [2:0] state
);

    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [TMR_W-1:0]  SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

    logic [2:0]        r_state;
    logic [4:0]        r_c;
    logic [4:0]        r_d;
    logic [4:0]        r_u;
    logic [1:0]        r_count;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic              r_open;
    logic              r_error;

    logic [2:0]        w_state_nxt;
    logic [4:0]        w_c_nxt;
    logic [4:0]        w_d_nxt;
    logic [4:0]        w_u_nxt;
    logic [1:0]        w_count_nxt;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;

    logic              w_enter_edge;
    key_event_e        w_event;
    logic              w_code_match;
    logic [FAIL_W-1:0] w_fail_inc;

    btn_sync_edge u_enter_sync (
        .clk    (clk),
        .rst_n  (reset),
        .i_btn  (enter),
        .o_rise (w_enter_edge)
    );

    assign w_event      = decode_key(key_valid, key_code, w_enter_edge);
    assign w_code_match = (r_c == {1'b0, CODE[11:8]}) &&
                          (r_d == {1'b0, CODE[7:4]})  &&
                          (r_u == {1'b0, CODE[3:0]});
    assign w_fail_inc   = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_u_nxt     = r_u;
        w_count_nxt = r_count;
        w_fail_nxt  = r_fail_cnt;
        w_timer_nxt = r_timer;

        case (r_state)
            ST_IDLE: begin
                if (w_event == KEV_DIGIT) begin
                    w_u_nxt     = key_code;
                    w_count_nxt = 2'd1;
                    w_state_nxt = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                case (w_event)
                    KEV_DIGIT: begin
                        if (r_count != 2'd3) begin
                            w_c_nxt     = r_d;
                            w_d_nxt     = r_u;
                            w_u_nxt     = key_code;
                            w_count_nxt = r_count + 2'd1;
                        end
                    end
                    KEV_CLEAR: begin
                        w_c_nxt     = GLYPH_BLANK;
                        w_d_nxt     = GLYPH_BLANK;
                        w_u_nxt     = GLYPH_BLANK;
                        w_count_nxt = 2'd0;
                        w_state_nxt = ST_IDLE;
                    end
                    KEV_ENTER: begin
                        if (r_count == 2'd3) begin
                            w_state_nxt = ST_CHECK;
                        end else begin
                            w_state_nxt = ST_ERROR;
                            w_fail_nxt  = w_fail_inc;
                            w_timer_nxt = SHOW_LOAD;
                        end
                    end
                    default: ;
                endcase
            end

            ST_CHECK: begin
                w_timer_nxt = SHOW_LOAD;
                if (w_code_match) begin
                    w_state_nxt = ST_OPEN;
                    w_fail_nxt  = '0;
                end else begin
                    w_state_nxt = ST_ERROR;
                    w_fail_nxt  = w_fail_inc;
                end
            end

            ST_OPEN, ST_ERROR: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (r_state == ST_ERROR && r_fail_cnt == FAIL_MAX) begin
                    w_state_nxt = ST_LOCKED;
                    w_c_nxt     = GLYPH_LOCK;
                    w_d_nxt     = GLYPH_LOCK;
                    w_u_nxt     = GLYPH_LOCK;
                    w_count_nxt = 2'd0;
                    w_timer_nxt = LOCK_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = GLYPH_BLANK;
                    w_d_nxt     = GLYPH_BLANK;
                    w_u_nxt     = GLYPH_BLANK;
                    w_count_nxt = 2'd0;
                end
            end

            ST_LOCKED: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_c_nxt     = GLYPH_BLANK;
                    w_d_nxt     = GLYPH_BLANK;
                    w_u_nxt     = GLYPH_BLANK;
                    w_count_nxt = 2'd0;
                    w_fail_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_c_nxt     = GLYPH_BLANK;
                w_d_nxt     = GLYPH_BLANK;
                w_u_nxt     = GLYPH_BLANK;
                w_count_nxt = 2'd0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_c        <= GLYPH_BLANK;
            r_d        <= GLYPH_BLANK;
            r_u        <= GLYPH_BLANK;
            r_count    <= 2'd0;
            r_fail_cnt <= '0;
            r_timer    <= '0;
            r_open     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_c        <= w_c_nxt;
            r_d        <= w_d_nxt;
            r_u        <= w_u_nxt;
            r_count    <= w_count_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_timer    <= w_timer_nxt;
            r_open     <= (w_state_nxt == ST_OPEN);
            r_error    <= (w_state_nxt == ST_ERROR) || (w_state_nxt == ST_LOCKED);
        end
    end

    assign c     = r_c;
    assign d     = r_d;
    assign u     = r_u;
    assign open  = r_open;
    assign error = r_error;
    assign state = r_state;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - scoreboard bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;
    import keypad_entry_ctrl_pkg::*;

    localparam logic [4:0] BL = 5'h1F;
    localparam logic [4:0] LK = 5'h0E;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code  = 5'd0;
    logic       enter     = 1'b0;
    logic [4:0] c, d, u;
    logic       open, error;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } exp_t;
    exp_t sb_q[$];

    logic [19:0] w_obs;
    assign w_obs = {state, c, d, u, open, error};

    always #5 clk = ~clk;

    keypad_entry_ctrl #(
        .CODE        (12'h147),
        .SHOW_CYCLES (8),
        .MAX_FAILS   (3),
        .LOCK_CYCLES (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .enter     (enter),
        .c         (c),
        .d         (d),
        .u         (u),
        .open      (open),
        .error     (error),
        .state     (state)
    );

    task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed {st,c,d,u,o,e}=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [4:0] ec,
                              input logic [4:0] ed, input logic [4:0] eu, input logic eo,
                              input logic ee);
        exp_t e;
        e.tag = tag;
        e.exp = {st, ec, ed, eu, eo, ee};
        sb_q.push_back(e);
    endtask

    task automatic sb_check_now();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 20'd1, 20'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, w_obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) sb_check_now();
    endtask

    task automatic press(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_leave(input logic [2:0] from, input int maxc, input string tag);
        int n;
        n = 0;
        while (state == from && n < maxc) begin
            tick();
            n++;
        end
        check_eq(tag, {19'd0, state == from}, 20'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        expect_out("reset_state", ST_IDLE, BL, BL, BL, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // correct code opens for exactly eight cycles
        expect_out("ok_k1", ST_ENTRY, BL, BL, 5'd1, 1'b0, 1'b0); press(5'd1);
        expect_out("ok_k4", ST_ENTRY, BL, 5'd1, 5'd4, 1'b0, 1'b0); press(5'd4);
        expect_out("ok_k7", ST_ENTRY, 5'd1, 5'd4, 5'd7, 1'b0, 1'b0); press(5'd7);
        expect_out("ok_check", ST_CHECK, 5'd1, 5'd4, 5'd7, 1'b0, 1'b0); press(KEY_ENTER);
        for (int i = 0; i < 8; i++) begin
            expect_out("ok_open", ST_OPEN, 5'd1, 5'd4, 5'd7, 1'b1, 1'b0);
            tick();
        end
        expect_out("ok_idle", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); tick();

        // clear/enter/unknown ignored in IDLE, fourth digit ignored, clear blanks
        expect_out("idle_clear", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); press(KEY_CLEAR);
        expect_out("idle_enter", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); press(KEY_ENTER);
        expect_out("idle_unk", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); press(5'h0B);
        expect_out("ov_k1", ST_ENTRY, BL, BL, 5'd1, 1'b0, 1'b0); press(5'd1);
        expect_out("ov_k4", ST_ENTRY, BL, 5'd1, 5'd4, 1'b0, 1'b0); press(5'd4);
        expect_out("ov_k7", ST_ENTRY, 5'd1, 5'd4, 5'd7, 1'b0, 1'b0); press(5'd7);
        expect_out("ov_k9", ST_ENTRY, 5'd1, 5'd4, 5'd7, 1'b0, 1'b0); press(5'd9);
        expect_out("ov_unk", ST_ENTRY, 5'd1, 5'd4, 5'd7, 1'b0, 1'b0); press(5'h0C);
        expect_out("ov_clear", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); press(KEY_CLEAR);

        // three wrong codes lead to LOCKED for twenty cycles
        for (int k = 0; k < 3; k++) begin
            expect_out("bad_k1", ST_ENTRY, BL, BL, 5'd2, 1'b0, 1'b0); press(5'd2);
            expect_out("bad_k2", ST_ENTRY, BL, 5'd2, 5'd2, 1'b0, 1'b0); press(5'd2);
            expect_out("bad_k3", ST_ENTRY, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0); press(5'd2);
            expect_out("bad_check", ST_CHECK, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0); press(KEY_ENTER);
            for (int i = 0; i < 8; i++) begin
                expect_out("bad_error", ST_ERROR, 5'd2, 5'd2, 5'd2, 1'b0, 1'b1);
                tick();
            end
            if (k == 2) expect_out("bad_locked", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1);
            else        expect_out("bad_idle", ST_IDLE, BL, BL, BL, 1'b0, 1'b0);
            tick();
        end
        expect_out("lock_k1", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1); press(5'd1);
        expect_out("lock_k4", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1); press(5'd4);
        expect_out("lock_k7", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1); press(5'd7);
        expect_out("lock_ent", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1); press(KEY_ENTER);
        for (int i = 0; i < 15; i++) begin
            expect_out("lock_hold", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1);
            tick();
        end
        expect_out("lock_exit", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); tick();

        // short entry via push-button, then fail count must start from zero
        expect_out("short_k5", ST_ENTRY, BL, BL, 5'd5, 1'b0, 1'b0); press(5'd5);
        expect_out("short_k6", ST_ENTRY, BL, 5'd5, 5'd6, 1'b0, 1'b0); press(5'd6);
        enter = 1'b1;
        wait_leave(ST_ENTRY, 8, "short_btn_timeout");
        expect_out("short_error", ST_ERROR, BL, 5'd5, 5'd6, 1'b0, 1'b1); sb_check_now();
        enter = 1'b0;
        wait_leave(ST_ERROR, 12, "short_err_timeout");
        expect_out("short_idle", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); sb_check_now();

        // key strobe coincident with the button edge: digit taken, enter dropped
        expect_out("same_k5", ST_ENTRY, BL, BL, 5'd5, 1'b0, 1'b0); press(5'd5);
        expect_out("same_k6", ST_ENTRY, BL, 5'd5, 5'd6, 1'b0, 1'b0); press(5'd6);
        enter = 1'b1;
        tick();
        tick();
        expect_out("same_k3", ST_ENTRY, 5'd5, 5'd6, 5'd3, 1'b0, 1'b0); press(5'd3);
        for (int i = 0; i < 3; i++) begin
            expect_out("same_hold", ST_ENTRY, 5'd5, 5'd6, 5'd3, 1'b0, 1'b0);
            tick();
        end
        enter = 1'b0;
        repeat (3) tick();
        expect_out("same_check", ST_CHECK, 5'd5, 5'd6, 5'd3, 1'b0, 1'b0); press(KEY_ENTER);
        expect_out("same_error", ST_ERROR, 5'd5, 5'd6, 5'd3, 1'b0, 1'b1); tick();
        wait_leave(ST_ERROR, 12, "same_err_timeout");
        expect_out("same_idle", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); sb_check_now();

        // asynchronous reset during OPEN
        press(5'd1); press(5'd4); press(5'd7); press(KEY_ENTER);
        expect_out("rst_open_pre", ST_OPEN, 5'd1, 5'd4, 5'd7, 1'b1, 1'b0); tick();
        tick();
        #2 reset = 1'b0;
        #1;
        expect_out("rst_open_async", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); sb_check_now();
        tick();
        reset = 1'b1;
        tick();

        // asynchronous reset during LOCKED
        for (int k = 0; k < 3; k++) begin
            press(5'd2); press(5'd2); press(5'd2); press(KEY_ENTER);
            repeat (9) tick();
        end
        expect_out("rst_lock_pre", ST_LOCKED, LK, LK, LK, 1'b0, 1'b1); tick();
        #2 reset = 1'b0;
        #1;
        expect_out("rst_lock_async", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); sb_check_now();

        // button held across reset release gives no edge; fail count not retained
        enter = 1'b1;
        tick();
        reset = 1'b1;
        expect_out("held_k5", ST_ENTRY, BL, BL, 5'd5, 1'b0, 1'b0); press(5'd5);
        for (int i = 0; i < 5; i++) begin
            expect_out("held_noedge", ST_ENTRY, BL, BL, 5'd5, 1'b0, 1'b0);
            tick();
        end
        enter = 1'b0;
        repeat (4) tick();
        enter = 1'b1;
        wait_leave(ST_ENTRY, 8, "held_btn_timeout");
        expect_out("held_error", ST_ERROR, BL, BL, 5'd5, 1'b0, 1'b1); sb_check_now();
        wait_leave(ST_ERROR, 12, "held_err_timeout");
        expect_out("held_idle", ST_IDLE, BL, BL, BL, 1'b0, 1'b0); sb_check_now();
        enter = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
